// File: rtl/config_readback_pkg.sv
// config_readback_pkg: shared constants, FSM states and snapshot layout for the config readback frame
package config_pkg;
  localparam logic [7:0] HEADER_DEF = 8'hA5;
  localparam int FRAME_LEN = 24;
  localparam logic [4:0] IDX_CHSEL = 5'd1;
  localparam logic [4:0] IDX_ALINE = 5'd2;
  localparam logic [4:0] IDX_PULSE = 5'd3;
  localparam logic [4:0] IDX_DELAY = 5'd7;
  localparam logic [4:0] IDX_CSUM = 5'd23;
  typedef enum logic [2:0] {IDLE, SEND, WAIT_HI, WAIT_LO, GAP, DONE} state_t;
  typedef struct packed {
    logic [7:0] chsel;
    logic [4:0] aline;
    logic [31:0] pulse;
    logic [127:0] delays;
  } cfg_t;
endpackage

// File: rtl/config_readback_if.sv
// config_readback_if: UART TX byte handshake (tx_data/tx_start from the serializer, tx_busy back from the transmitter)
interface config_readback_if;
  logic [7:0] tx_data;
  logic tx_start;
  logic tx_busy;
  modport master(output tx_data, output tx_start, input tx_busy);
  modport slave(input tx_data, input tx_start, output tx_busy);
endinterface

// File: rtl/config_readback_frame_byte_select.sv
// frame_byte_select: combinational mux returning frame byte i_idx of the snapshot
// Ports: i_cfg snapshot, i_idx byte index 0..23, i_csum running checksum, o_byte selected byte
module frame_byte_select
  import config_pkg::*;
#(
  parameter logic [7:0] HEADER = HEADER_DEF
) (
  input  cfg_t       i_cfg,
  input  logic [4:0] i_idx,
  input  logic [7:0] i_csum,
  output logic [7:0] o_byte
);
  logic [1:0] w_p;
  logic [3:0] w_d;
  logic [7:0] w_pulse_byte;
  logic [7:0] w_delay_byte;
  assign w_p = 2'(i_idx - IDX_PULSE);
  assign w_d = 4'(i_idx - IDX_DELAY);
  // pulse goes MSB first: byte p sits at bit offset 8*(3-p)
  assign w_pulse_byte = 8'(i_cfg.pulse >> {~w_p, 3'b000});
  // channel w_d[3:1]; even offset is the high byte (+8), odd the low byte
  assign w_delay_byte = 8'(i_cfg.delays >> {w_d[3:1], ~w_d[0], 3'b000});
  always_comb
    o_byte = (i_idx == 5'd0)      ? HEADER :
             (i_idx == IDX_CHSEL) ? i_cfg.chsel :
             (i_idx == IDX_ALINE) ? {3'b000, i_cfg.aline} :
             (i_idx <  IDX_DELAY) ? w_pulse_byte :
             (i_idx <  IDX_CSUM)  ? w_delay_byte : i_csum;
endmodule

// File: rtl/config_readback.sv
// config_readback: snapshots the stored configuration and streams it as a 24-byte checksummed frame to a UART TX
// Ports: clk, rst (async active-low), start/intaking_configs request gating, channel_select/aline_select/
// pulse_shape/delays config inputs, tx (byte handshake master), busy/done frame status
module config_readback
  import config_pkg::*;
#(
  parameter logic [7:0] HEADER = HEADER_DEF,
  parameter int GAP_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                intaking_configs,
  input  logic [7:0]          channel_select,
  input  logic [4:0]          aline_select,
  input  logic [31:0]         pulse_shape,
  input  logic [127:0]        delays,
  config_readback_if.master   tx,
  output logic                busy,
  output logic                done
);
  state_t r_state, w_next;
  cfg_t r_cfg;
  logic [4:0] r_idx;
  logic [7:0] r_csum;
  logic [7:0] r_tx_data;
  logic r_tx_start;
  logic [15:0] r_gap;
  logic [7:0] w_byte;
  logic w_load, w_send, w_adv;
  frame_byte_select #(.HEADER(HEADER)) u_sel (
    .i_cfg (r_cfg),
    .i_idx (r_idx),
    .i_csum(r_csum),
    .o_byte(w_byte)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_send = 1'b0;
    w_adv = 1'b0;
    case (r_state)
      IDLE: begin
        w_load = start && !intaking_configs;
        w_next = w_load ? SEND : IDLE;
      end
      SEND: begin
        w_send = !tx.tx_busy;
        w_next = w_send ? WAIT_HI : SEND;
      end
      WAIT_HI: w_next = tx.tx_busy ? WAIT_LO : WAIT_HI;
      WAIT_LO: begin
        w_adv = !tx.tx_busy && r_idx != IDX_CSUM;
        w_next = tx.tx_busy ? WAIT_LO : (r_idx == IDX_CSUM) ? DONE : (GAP_CYCLES > 0) ? GAP : SEND;
      end
      GAP: w_next = (r_gap == 16'(GAP_CYCLES - 1)) ? SEND : GAP;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_cfg <= '0;
      r_idx <= '0;
      r_csum <= '0;
      r_tx_data <= '0;
      r_tx_start <= 1'b0;
      r_gap <= '0;
    end else begin
      r_tx_start <= w_send;
      r_gap <= (r_state == GAP) ? r_gap + 16'd1 : '0;
      if (w_load) begin
        r_cfg <= '{chsel: channel_select, aline: aline_select, pulse: pulse_shape, delays: delays};
        r_idx <= '0;
        r_csum <= '0;
      end
      if (w_send) begin
        r_tx_data <= w_byte;
        // header and the checksum byte itself are excluded from the sum
        if (r_idx >= IDX_CHSEL && r_idx < IDX_CSUM) r_csum <= r_csum + w_byte;
      end
      if (w_adv) r_idx <= r_idx + 5'd1;
    end
  assign tx.tx_data = r_tx_data;
  assign tx.tx_start = r_tx_start;
  assign busy = r_state != IDLE && r_state != DONE;
  assign done = r_state == DONE;
endmodule

// File: tb/tb_config_readback.sv
// tb_config_readback: directed and randomized frame checks of config_readback against a byte-list model
module tb_config_readback;
  logic clk = 0;
  logic rst = 0;
  logic start = 0;
  logic intaking_configs = 0;
  logic [7:0] channel_select = 0;
  logic [4:0] aline_select = 0;
  logic [31:0] pulse_shape = 0;
  logic [127:0] delays = 0;
  logic busy, done;
  int checks = 0;
  int failures = 0;
  logic [7:0] got[$];
  int n_done = 0;
  int n_start = 0;
  int n_early = 0;
  bit stall = 0;
  int cnt = 0;
  config_readback_if txi();
  config_readback dut (
    .clk(clk), .rst(rst), .start(start), .intaking_configs(intaking_configs),
    .channel_select(channel_select), .aline_select(aline_select),
    .pulse_shape(pulse_shape), .delays(delays), .tx(txi), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  initial begin
    txi.tx_busy = 0;
    forever begin
      @(posedge clk);
      #1;
      if (done) n_done++;
      if (stall) begin
        txi.tx_busy = 1;
        if (txi.tx_start) n_early++;
      end else if (cnt > 0) begin
        cnt--;
        txi.tx_busy = (cnt != 0);
      end else begin
        txi.tx_busy = 0;
        if (txi.tx_start) begin
          got.push_back(txi.tx_data);
          n_start++;
          cnt = 10;
          txi.tx_busy = 1;
        end
      end
    end
  end
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic void build(input logic [7:0] cs, input logic [4:0] al, input logic [31:0] ps,
                                input logic [127:0] dl, output logic [7:0] f[24]);
    int s = 0;
    f[0] = 8'hA5;
    f[1] = cs;
    f[2] = {3'b000, al};
    for (int i = 0; i < 4; i++) f[3 + i] = 8'(ps >> (24 - 8 * i));
    for (int c = 0; c < 8; c++) begin
      f[7 + 2 * c] = 8'(dl >> (16 * c + 8));
      f[8 + 2 * c] = 8'(dl >> (16 * c));
    end
    for (int i = 1; i <= 22; i++) s += f[i];
    f[23] = 8'(s % 256);
  endfunction
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic send_frame(input string tag, input logic [7:0] cs, input logic [4:0] al,
                            input logic [31:0] ps, input logic [127:0] dl,
                            input bit stall_first, input bit restart_mid);
    logic [7:0] f[24];
    bit fired = 0;
    build(cs, al, ps, dl, f);
    channel_select = cs;
    aline_select = al;
    pulse_shape = ps;
    delays = dl;
    got.delete();
    n_done = 0;
    n_early = 0;
    stall = stall_first;
    start = 1;
    tick();
    start = 0;
    chk({tag, "_busy_on_start"}, busy, 1);
    if (stall_first) begin
      tick();
      channel_select = 8'hFF;
      repeat (200) tick();
      chk({tag, "_no_start_while_stalled"}, 128'(got.size() + n_early), 0);
      stall = 0;
    end else begin
      tick();
      chk({tag, "_tx_start_latency"}, txi.tx_start, 1);
    end
    for (int c = 0; c < 4000 && n_done == 0; c++) begin
      tick();
      if (restart_mid && !fired && got.size() == 3) begin
        start = 1;
        fired = 1;
      end else start = 0;
    end
    start = 0;
    repeat (40) tick();
    chk({tag, "_done_count"}, n_done, 1);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_len"}, got.size(), 24);
    for (int i = 0; i < 24; i++)
      chk($sformatf("%s_byte%0d", tag, i), (i < got.size()) ? got[i] : 8'hxx, f[i]);
  endtask
  initial begin
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tx_start", txi.tx_start, 0);
    chk("rst_tx_data", txi.tx_data, 0);
    repeat (2) tick();
    rst = 1;
    tick();
    send_frame("basic", 8'h1B, 5'd3, 32'h0, 128'h0, 0, 0);
    chk("basic_csum_const", got[23], 8'h1E);
    send_frame("wrap", 8'h1B, 5'd3, 32'hDEADBEEF, 128'h0, 0, 0);
    chk("wrap_csum_const", got[23], 8'h56);
    chk("wrap_b3", got[3], 8'hDE);
    send_frame("order", 8'h1B, 5'd3, 32'h0, {16'hABCD, 96'h0, 16'h1234}, 0, 0);
    chk("order_b7", got[7], 8'h12);
    chk("order_b8", got[8], 8'h34);
    chk("order_b21", got[21], 8'hAB);
    chk("order_b22", got[22], 8'hCD);
    intaking_configs = 1;
    n_start = 0;
    start = 1;
    tick();
    start = 0;
    repeat (50) tick();
    chk("gate_intaking_starts", n_start, 0);
    chk("gate_intaking_busy", busy, 0);
    intaking_configs = 0;
    send_frame("restart", 8'h5A, 5'd17, 32'h01020304, {8{16'hF00F}}, 0, 1);
    send_frame("stall", 8'h1B, 5'd3, 32'h0, 128'h0, 1, 0);
    chk("stall_b1_const", got[1], 8'h1B);
    channel_select = 8'h1B;
    got.delete();
    start = 1;
    tick();
    start = 0;
    for (int c = 0; c < 1000 && got.size() < 6; c++) tick();
    chk("rstmid_reached", got.size(), 6);
    #3;
    rst = 0;
    #1;
    chk("rstmid_tx_start", txi.tx_start, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    repeat (3) tick();
    rst = 1;
    for (int c = 0; c < 100 && txi.tx_busy; c++) tick();
    repeat (20) tick();
    chk("rstmid_no_resume", got.size(), 6);
    send_frame("after_rst", 8'h1B, 5'd3, 32'hCAFEF00D, 128'h0, 0, 0);
    chk("after_rst_header", got[0], 8'hA5);
    for (int r = 0; r < 3; r++)
      send_frame($sformatf("rand%0d", r), 8'($urandom), 5'($urandom), $urandom,
                 {$urandom, $urandom, $urandom, $urandom}, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
